// File: rtl/store_narrow_writer.sv
// Truncates a 32-bit store value to byte/half/word and writes it little-endian, one byte per beat.
// Latency: N beats for N bytes, done one cycle after the last beat, req_ready one cycle after that.
// Backpressure: a beat holds address/data/strobe until mem_ack; requests are taken only when idle.
module store_narrow_writer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   input  logic              sign_ext,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   output logic              done,
   output logic              range_ok,
   output logic              misalign_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WRITE  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]        state;
   logic [ADDR_W-1:0] base;
   logic [31:0]       data;
   logic [1:0]        idx;
   logic [1:0]        last;
   logic              ok_r;
   logic              err_r;

   logic              req_bad;
   logic              req_ok;
   logic [1:0]        req_last;

   // Classify the incoming request: alignment error, beat count and truncation losslessness
   always_comb begin
      req_bad  = 1'b0;
      req_ok   = 1'b1;
      req_last = 2'd0;
      case (req_size)
         SZ_BYTE: begin
            req_last = 2'd0;
            req_ok   = sign_ext ? ((&req_data[31:7]) | ~(|req_data[31:7]))
                                : ~(|req_data[31:8]);
         end
         SZ_HALF: begin
            req_last = 2'd1;
            req_bad  = req_addr[0];
            req_ok   = sign_ext ? ((&req_data[31:15]) | ~(|req_data[31:15]))
                                : ~(|req_data[31:16]);
         end
         SZ_WORD: begin
            req_last = 2'd3;
            req_bad  = |req_addr[1:0];
            req_ok   = 1'b1;
         end
         default: begin
            req_bad  = 1'b1;
            req_ok   = 1'b0;
         end
      endcase
   end

   // Control FSM: accept in IDLE, stream bytes in WRITE, report status for one cycle in FINISH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         base  <= '0;
         data  <= '0;
         idx   <= 2'd0;
         last  <= 2'd0;
         ok_r  <= 1'b0;
         err_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_bad) begin
                     err_r <= 1'b1;
                     ok_r  <= 1'b0;
                     state <= S_FINISH;
                  end else begin
                     base  <= req_addr;
                     data  <= req_data;
                     idx   <= 2'd0;
                     last  <= req_last;
                     ok_r  <= req_ok;
                     err_r <= 1'b0;
                     state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (mem_ack) begin
                  if (idx == last) begin
                     state <= S_FINISH;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded purely from registered state; address wraps naturally at 2^ADDR_W
   always_comb begin
      req_ready    = (state == S_IDLE);
      mem_we       = (state == S_WRITE);
      done         = (state == S_FINISH);
      range_ok     = done & ok_r;
      misalign_err = done & err_r;
      mem_addr     = '0;
      mem_wdata    = 8'h00;
      if (state == S_WRITE) begin
         mem_addr = base + ADDR_W'(idx);
         case (idx)
            2'd0:    mem_wdata = data[7:0];
            2'd1:    mem_wdata = data[15:8];
            2'd2:    mem_wdata = data[23:16];
            default: mem_wdata = data[31:24];
         endcase
      end
   end

endmodule

// File: doc/store_narrow_writer.md
Name: store_narrow_writer

Overview:
- Store-side counterpart of the load-path sign/zero extender.
- Takes a 32-bit register value plus a store size (byte/half/word) and truncates it to that size.
- Writes the result little-endian onto an 8-bit memory write port, one byte per accepted beat.
- Sits between the MEM pipeline stage and the byte-wide data memory. Flags whether the truncated value re-extends (under `sign_ext`) to the original register value.

Parameters:
- `ADDR_W`, 32, width of the store address and of `mem_addr`.

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  asynchronous reset, active-high
- `req_valid`  input  1  store request present
- `req_ready`  output  1  unit can accept a request (high only in IDLE)
- `req_addr`  input  ADDR_W  byte address of store
- `req_data`  input  32  register value to store
- `req_size`  input  2  00 byte, 01 half, 10 word, 11 illegal
- `sign_ext`  input  1  1 = range check as signed, 0 = unsigned
- `mem_we`  output  1  byte write strobe / beat valid
- `mem_addr`  output  ADDR_W  byte address of current beat
- `mem_wdata`  output  8  byte of current beat
- `mem_ack`  input  1  memory accepts the current beat this cycle
- `done`  output  1  one-cycle completion pulse
- `range_ok`  output  1  truncation lossless; valid while `done`=1
- `misalign_err`  output  1  request rejected; valid while `done`=1

Behaviour:
- **Reset** (async, immediate): state IDLE.
  - Outputs: `req_ready`=1; `mem_we`, `done`, `range_ok`, `misalign_err`=0; `mem_addr`=0; `mem_wdata`=0.
  - Reset during WRITE aborts the store. No further beats and no `done`.
- **FSM states:** IDLE, WRITE, FINISH. All outputs are registered or decoded from registered state; there is no combinational path from the request inputs to the outputs.
- **IDLE:** `req_ready`=1. A request is accepted on a rising edge with `req_valid`=1.
  - Error case: `req_size`=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0.
    - Go to FINISH with `misalign_err`=1 and `range_ok`=0.
    - No memory beat is issued.
  - Normal case:
    - Latch base address and data; `idx`=0; `last` = 0/1/3 for byte/half/word.
    - Compute `range_ok`:
      - byte: `sign_ext` ? `data[31:7]` all equal : `data[31:8]`==0
      - half: `sign_ext` ? `data[31:15]` all equal : `data[31:16]`==0
      - word: always 1
    - Go to WRITE.
- **WRITE:**
  - Outputs: `mem_we`=1, `mem_addr` = base + `idx` (mod 2^`ADDR_W`), `mem_wdata` = `data[8*idx+7 : 8*idx]`.
  - Beat completes on an edge with `mem_ack`=1. If `idx`==`last`, go to FINISH; else increment `idx`.
  - `mem_ack`=0 holds `mem_addr`, `mem_wdata` and `mem_we` stable indefinitely.
  - `mem_ack` is ignored outside WRITE.
- **FINISH:** `done`=1 for exactly one cycle, with `range_ok`/`misalign_err` valid; `mem_we`=0. Then go to IDLE.
- `range_ok` and `misalign_err` are 0 whenever `done`=0.
- **Latency:** with `mem_ack` tied high, N bytes take N WRITE cycles.
  - Accept edge at cycle 0; beats in cycles 1..N; `done` in cycle N+1.
  - `req_ready` rises again in cycle N+2.
  - Error path: `done` in cycle 1.
- `req_valid` while busy is ignored. The requester must hold the request until it sees `req_ready`=1 at an edge.

Test Plan:
- **Word store:** addr 0x100, data 0x11223344, size 10, ack high → beats (0x100,44)(0x101,33)(0x102,22)(0x103,11) in cycles 1–4; `done`=1 in cycle 5; `range_ok`=1; `misalign_err`=0.
- **Byte range check:** data 0xFFFFFF80, size 00 → single beat (addr,0x80). With `sign_ext`=1, `range_ok`=1; rerun with `sign_ext`=0, `range_ok`=0. Also data 0x00000180, `sign_ext`=0 → `range_ok`=0.
- **Halfword with backpressure:** addr 0x202, data 0x0000BEEF, `sign_ext`=0, `mem_ack` low 3 cycles per beat → (0x202,EF) held 4 cycles, then (0x203,BE) held 4 cycles; `done` one cycle after the second ack; `range_ok`=1.
- **Misalignment:**
  - half at 0x201 → no `mem_we`; `done`+`misalign_err` in cycle 1.
  - word at 0x102 → same response.
  - size 11 → same response.
- **Reset mid-store:** assert `rst` during beat 2 of a word store → `mem_we` falls asynchronously, no `done`. After release, `req_ready`=1, and a new byte store completes normally.
- **Address wrap:** word at 0xFFFFFFFC → beats at 0xFFFFFFFC..0xFFFFFFFF. A busy-time `req_valid` pulse produces no extra beats.
